// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the shift_deserializer block.
// The optional parity feature is enabled by defining SHIFT_DESER_PARITY_EN.
package shift_deser_pkg;

    typedef enum logic [1:0] {
        SD_COLLECT = 2'd0,
        SD_PARITY  = 2'd1,
        SD_HOLD    = 2'd2
    } sd_state_e;

    localparam logic SD_MSB_FIRST = 1'b0;
    localparam logic SD_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// Bit position counter for the deserializer: counts accepted bits 0..WIDTH-1
// and wraps to 0 on the increment that follows the last position.
module shift_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     last
);

    localparam int CW = $clog2(WIDTH);

    assign last = (cnt == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer, MSB- or LSB-first per word, valid/ready output.
// Define SHIFT_DESER_PARITY_EN to accept a trailing even-parity bit and expose m_perr.
module shift_deserializer
    import shift_deser_pkg::*;
#(
    parameter int   WIDTH         = 4,
    parameter logic lsb_first_def = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dir,
    input  logic             s_bit,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef SHIFT_DESER_PARITY_EN
    ,
    output logic             m_perr
`endif
);

    localparam int CW = $clog2(WIDTH);

    sd_state_e        state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic             word_dir;
    logic             eff_dir;
    logic             accept;
    logic             cnt_inc;
    logic             cnt_clr;
    logic [CW-1:0]    cnt;
    logic             cnt_last;

    assign s_ready = (state != SD_HOLD);
    assign accept  = s_valid && s_ready;
    assign cnt_inc = accept && (state == SD_COLLECT);
    assign cnt_clr = (state == SD_HOLD);

    // The first bit of a word uses the live dir so a same-cycle change takes effect.
    assign eff_dir = (cnt == '0) ? dir : word_dir;

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sh_next = sh;
        if (eff_dir == SD_LSB_FIRST) begin
            sh_next = {s_bit, sh[WIDTH-1:1]};
        end else begin
            sh_next = {sh[WIDTH-2:0], s_bit};
        end
    end

    shift_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SD_COLLECT;
            sh       <= '0;
            word_dir <= lsb_first_def;
            m_data   <= '0;
            m_valid  <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
            m_perr   <= 1'b0;
`endif
        end else begin
            case (state)
                SD_COLLECT: begin
                    if (accept) begin
                        sh <= sh_next;
                        if (cnt == '0) begin
                            word_dir <= dir;
                        end
                        if (cnt_last) begin
                            m_data <= sh_next;
`ifdef SHIFT_DESER_PARITY_EN
                            state  <= SD_PARITY;
`else
                            state   <= SD_HOLD;
                            m_valid <= 1'b1;
`endif
                        end
                    end
                end
`ifdef SHIFT_DESER_PARITY_EN
                SD_PARITY: begin
                    if (accept) begin
                        m_perr  <= (^m_data) ^ s_bit;
                        m_valid <= 1'b1;
                        state   <= SD_HOLD;
                    end
                end
`endif
                SD_HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= SD_COLLECT;
                    end
                end
                default: begin
                    state   <= SD_COLLECT;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
